fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and instruction-register stage that sits directly upstream of the control unit and datapath.
- Owns the 8-bit program counter and drives the code memory address.
- Latches the 16-bit instruction returned combinationally by code memory and splits it into its fields.
- Holds each instruction stable until the executing stage signals completion; handles jumps and the STOP opcode.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset and on start.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins execution from RESET_PC when in IDLE or HALT.
- code_addr  out  8  address to code memory; always equals pc.
- code_data  in  16  instruction word from code memory, combinational on code_addr.
- ir  out  16  instruction register.
- opcode  out  5  ir[15:11].
- ra  out  3  ir[10:8].
- rb  out  3  ir[2:0] (format A).
- inmk  out  8  ir[7:0] (format B immediate).
- ir_valid  out  1  ir holds a non-STOP instruction awaiting execution.
- exec_done  in  1  executing stage has finished the current instruction; sampled only while ir_valid=1.
- jump_en  in  1  qualifies exec_done; load jump_addr into the PC instead of keeping the incremented value.
- jump_addr  in  8  jump target.
- halted  out  1  STOP has been reached.
- busy  out  1  state is FETCH or EXEC.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, pc=RESET_PC, ir=16'h0000, instr_count=0.
  - ir_valid=0, halted=0, busy=0.
  - Applies immediately from any state, including mid-instruction.
- Field outputs (opcode, ra, rb, inmk) are pure combinational slices of ir.
- code_addr=pc continuously.
- IDLE:
  - Wait for start=1; then pc<=RESET_PC and go to FETCH.
  - All other inputs are ignored.
- FETCH (exactly one cycle):
  - ir<=code_data, i.e. the word at address pc.
  - pc<=pc+1 modulo 256, so 8'hFF wraps to 8'h00.
  - Go to EXEC.
  - Fetch latency is 1 cycle: the instruction appears on ir in the cycle after FETCH.
- EXEC, opcode==`STOP:
  - ir_valid stays 0; go to HALT next cycle.
  - instr_count is not incremented.
- EXEC, other opcodes:
  - ir_valid=1 (combinational from state and opcode).
  - Hold ir and pc stable until exec_done=1.
  - On exec_done: if jump_en=1, pc<=jump_addr; otherwise pc keeps its already-incremented value.
  - On exec_done: instr_count<=instr_count+1, saturating at all-ones.
  - On exec_done: go to FETCH.
  - Minimum throughput is one instruction per 2 cycles (exec_done asserted in the first EXEC cycle).
- HALT:
  - halted=1; pc and ir hold; the STOP word remains visible on ir.
  - start=1: pc<=RESET_PC, halted<=0, instr_count<=0, go to FETCH.
- Boundary rules:
  - jump_en without exec_done is ignored.
  - exec_done outside EXEC, or while a STOP is in ir, is ignored.
  - start in FETCH or EXEC is ignored (no restart mid-program).
  - A jump to the address of the current instruction is legal (tight loop); the PC reloads normally.
  - Opcodes other than `STOP are not interpreted; ra/rb/inmk are presented regardless of format.
- busy=1 in FETCH and EXEC.

Decomposition:
- Opcode and register macros (`STOP, `MOV, `ADD, `LDI, `SUB, `R0..`R7) stay in the shared globals.vh; no new opcodes.
- Add to globals.vh: state encodings FU_IDLE, FU_FETCH, FU_EXEC, FU_HALT (2 bits), and instruction field bit positions.
- No sub-module is natural; the PC, IR, counter and FSM are one module.
- Integration: the testbench instantiates code_mem alongside this block, with code_addr driving code_mem's address input and code_mem's data output feeding code_data.

Test Plan:
- Reset then start with the standard program (h0..h6) and exec_done tied to 1 → ir sequence MOV, MOV, ADD, LDI(inmk=8'h05), SUB, MOV, STOP; halted=1 at cycle 15 after start; instr_count=6; pc=8'h07.
- exec_done held low 5 cycles on h2 → ir, ra=`R0 and rb=`R1 hold stable; ir_valid=1 throughout; pc=8'h03 throughout.
- At address h4, exec_done=1 with jump_en=1 and jump_addr=8'h01 → next fetch is address h01; instr_count continues incrementing.
- jump_en=1 while exec_done=0 → no PC change; start pulse during EXEC → no restart.
- Jump to 8'hFF containing a non-STOP word → next fetch is at address 8'h00 (wrap).
- reset low mid-EXEC → all outputs zero and state IDLE asynchronously; a following start pulse fetches from 8'h00. Start in HALT → instr_count=0 and fetch restarts from 8'h00.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage:
// opcodes, register names, FSM states and IR field positions.
package fetch_unit_pkg;

    // Opcodes (ir[15:11])
    localparam logic [4:0] OP_MOV  = 5'h01;
    localparam logic [4:0] OP_ADD  = 5'h02;
    localparam logic [4:0] OP_LDI  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_STOP = 5'h1F;

    // Register names
    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FU_IDLE  = 2'd0,
        FU_FETCH = 2'd1,
        FU_EXEC  = 2'd2,
        FU_HALT  = 2'd3
    } fu_state_e;

    // Instruction field bit positions
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 11;
    localparam int RA_HI  = 10;
    localparam int RA_LO  = 8;
    localparam int RB_HI  = 2;
    localparam int RB_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch + instruction register stage.
// Owns the PC, latches code_data into ir, waits for exec_done,
// handles jumps and STOP, and counts retired instructions.
// Ports:
//   clk, reset (async, active low), start (run pulse)
//   code_addr -> code memory, code_data <- code memory
//   ir / opcode / ra / rb / inmk : instruction and its fields
//   ir_valid : non-STOP instruction awaiting execution
//   exec_done, jump_en, jump_addr : completion from execute
//   halted, busy, instr_count : status
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [7:0]       code_addr,
    input  logic [15:0]      code_data,
    output logic [15:0]      ir,
    output logic [4:0]       opcode,
    output logic [2:0]       ra,
    output logic [2:0]       rb,
    output logic [7:0]       inmk,
    output logic             ir_valid,
    input  logic             exec_done,
    input  logic             jump_en,
    input  logic [7:0]       jump_addr,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    fu_state_e        state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_stop;

    assign is_stop = (ir_q[OPC_HI:OPC_LO] == OP_STOP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FU_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FU_IDLE: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = FU_FETCH;
                end
            end
            FU_FETCH: begin
                ir_d    = code_data;
                pc_d    = pc_q + 8'd1;
                state_d = FU_EXEC;
            end
            FU_EXEC: begin
                // STOP never retires; it parks in HALT
                if (is_stop) begin
                    state_d = FU_HALT;
                end else if (exec_done) begin
                    if (jump_en) begin
                        pc_d = jump_addr;
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    state_d = FU_FETCH;
                end
            end
            FU_HALT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                    state_d = FU_FETCH;
                end
            end
            default: state_d = FU_IDLE;
        endcase
    end

    assign code_addr   = pc_q;
    assign ir          = ir_q;
    assign opcode      = ir_q[OPC_HI:OPC_LO];
    assign ra          = ir_q[RA_HI:RA_LO];
    assign rb          = ir_q[RB_HI:RB_LO];
    assign inmk        = ir_q[IMM_HI:IMM_LO];
    assign ir_valid    = (state_q == FU_EXEC) && !is_stop;
    assign halted      = (state_q == FU_HALT);
    assign busy        = (state_q == FU_FETCH) ||
                         (state_q == FU_EXEC);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a behavioural
// code memory, vector table, corner sequences and random run.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        exec_done;
    logic        jump_en;
    logic [7:0]  jump_addr;
    logic [7:0]  code_addr;
    logic [15:0] code_data;
    logic [15:0] ir;
    logic [4:0]  opcode;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [7:0]  inmk;
    logic        ir_valid;
    logic        halted;
    logic        busy;
    logic [15:0] instr_count;

    // second instance with a tiny counter to reach saturation
    logic [7:0]  code_addr2;
    logic [15:0] code_data2;
    logic [15:0] ir2;
    logic [4:0]  opcode2;
    logic [2:0]  ra2;
    logic [2:0]  rb2;
    logic [7:0]  inmk2;
    logic        ir_valid2;
    logic        halted2;
    logic        busy2;
    logic [1:0]  cnt2;

    logic [15:0] mem [256];

    assign code_data  = mem[code_addr];
    assign code_data2 = mem[code_addr2];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(8'h00), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .code_addr(code_addr), .code_data(code_data),
        .ir(ir), .opcode(opcode), .ra(ra), .rb(rb),
        .inmk(inmk), .ir_valid(ir_valid),
        .exec_done(exec_done), .jump_en(jump_en),
        .jump_addr(jump_addr), .halted(halted),
        .busy(busy), .instr_count(instr_count)
    );

    fetch_unit #(.RESET_PC(8'h00), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start),
        .code_addr(code_addr2), .code_data(code_data2),
        .ir(ir2), .opcode(opcode2), .ra(ra2), .rb(rb2),
        .inmk(inmk2), .ir_valid(ir_valid2),
        .exec_done(exec_done), .jump_en(jump_en),
        .jump_addr(jump_addr), .halted(halted2),
        .busy(busy2), .instr_count(cnt2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // complete the current instruction, then step through FETCH
    task automatic retire(input logic j, input logic [7:0] ja);
        exec_done = 1'b1;
        jump_en   = j;
        jump_addr = ja;
        tick();
        exec_done = 1'b0;
        jump_en   = 1'b0;
        tick();
    endtask

    function automatic logic [15:0] enc_a(input logic [4:0] op,
                                          input logic [2:0] a,
                                          input logic [2:0] b);
        return {op, a, 5'b00000, b};
    endfunction

    function automatic logic [15:0] enc_b(input logic [4:0] op,
                                          input logic [2:0] a,
                                          input logic [7:0] imm);
        return {op, a, imm};
    endfunction

    typedef struct {
        logic [15:0] ir;
        logic [4:0]  op;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [7:0]  imm;
        logic        valid;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [15:0] w;
        logic [15:0] hold_ir;
        logic [7:0]  exp_addr;
        int          exp_cnt;
        int          d;
        logic        j;
        logic [7:0]  ja;

        reset     = 1'b0;
        start     = 1'b0;
        exec_done = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 8'h00;

        for (int a = 0; a < 256; a++)
            mem[a] = enc_a(OP_MOV, R1, R2);
        mem[0] = enc_a(OP_MOV, R0, R2);
        mem[1] = enc_a(OP_MOV, R1, R3);
        mem[2] = enc_a(OP_ADD, R0, R1);
        mem[3] = enc_b(OP_LDI, R2, 8'h05);
        mem[4] = enc_a(OP_SUB, R0, R2);
        mem[5] = enc_a(OP_MOV, R3, R0);
        mem[6] = {OP_STOP, 11'h000};
        mem[8'hFF] = enc_a(OP_ADD, R7, R6);

        tbl[0] = '{16'h0802, OP_MOV, R0, R2, 8'h02, 1'b1};
        tbl[1] = '{16'h0903, OP_MOV, R1, R3, 8'h03, 1'b1};
        tbl[2] = '{16'h1001, OP_ADD, R0, R1, 8'h01, 1'b1};
        tbl[3] = '{16'h1A05, OP_LDI, R2, R5, 8'h05, 1'b1};
        tbl[4] = '{16'h2002, OP_SUB, R0, R2, 8'h02, 1'b1};
        tbl[5] = '{16'h0B00, OP_MOV, R3, R0, 8'h00, 1'b1};
        tbl[6] = '{16'hF800, OP_STOP, R0, R0, 8'h00, 1'b0};

        // reset state
        #12;
        chk("rst_pc", code_addr, 8'h00);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", instr_count, 16'd0);
        tick();
        reset = 1'b1;
        tick();
        exec_done = 1'b1;
        tick();
        chk("idle_ignores", busy, 1'b0);

        // standard program, exec_done tied high
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_pc", code_addr, 8'h00);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("t%0d_ir", i), ir, tbl[i].ir);
            chk($sformatf("t%0d_op", i), opcode, tbl[i].op);
            chk($sformatf("t%0d_ra", i), ra, tbl[i].ra);
            chk($sformatf("t%0d_rb", i), rb, tbl[i].rb);
            chk($sformatf("t%0d_imm", i), inmk, tbl[i].imm);
            chk($sformatf("t%0d_vld", i), ir_valid,
                tbl[i].valid);
            chk($sformatf("t%0d_pc", i), code_addr, i + 1);
            chk($sformatf("t%0d_cnt", i), instr_count, i);
            chk($sformatf("t%0d_hlt", i), halted, 1'b0);
            tick();
        end
        chk("halt_at_15", halted, 1'b1);
        chk("halt_cnt", instr_count, 16'd6);
        chk("halt_pc", code_addr, 8'h07);
        chk("halt_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_hold_ir", ir, 16'hF800);
            chk("halt_hold_pc", code_addr, 8'h07);
            chk("halt_hold_cnt", instr_count, 16'd6);
        end
        exec_done = 1'b0;

        // restart from HALT
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_cnt", instr_count, 16'd0);
        chk("rs_halted", halted, 1'b0);
        chk("rs_pc", code_addr, 8'h00);
        tick();
        chk("rs_ir0", ir, mem[0]);
        retire(1'b0, 8'h00);
        retire(1'b0, 8'h00);

        // hold on h2, with ignored jump_en and start
        for (int i = 0; i < 5; i++) begin
            jump_en   = 1'b1;
            jump_addr = 8'hAA;
            start     = (i == 2);
            tick();
            chk("hold_ir", ir, 16'h1001);
            chk("hold_ra", ra, R0);
            chk("hold_rb", rb, R1);
            chk("hold_vld", ir_valid, 1'b1);
            chk("hold_pc", code_addr, 8'h03);
            chk("hold_busy", busy, 1'b1);
        end
        jump_en = 1'b0;
        start   = 1'b0;
        retire(1'b0, 8'h00);
        chk("ldi_imm", inmk, 8'h05);
        retire(1'b0, 8'h00);
        chk("sub_ir", ir, 16'h2002);
        chk("cnt_at_h4", instr_count, 16'd4);

        // jump back to h1
        retire(1'b1, 8'h01);
        chk("jmp_ir", ir, mem[1]);
        chk("jmp_pc", code_addr, 8'h02);
        chk("jmp_cnt", instr_count, 16'd5);

        // jump to FF then wrap to 00
        retire(1'b1, 8'hFF);
        chk("ff_ir", ir, 16'h1706);
        chk("ff_pc", code_addr, 8'h00);
        retire(1'b0, 8'h00);
        chk("wrap_ir", ir, mem[0]);
        chk("wrap_pc", code_addr, 8'h01);
        chk("wrap_cnt", instr_count, 16'd7);

        // asynchronous reset mid-EXEC
        #2;
        reset = 1'b0;
        #1;
        chk("ar_ir", ir, 16'h0000);
        chk("ar_pc", code_addr, 8'h00);
        chk("ar_vld", ir_valid, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_cnt", instr_count, 16'd0);
        #1;
        reset = 1'b1;
        tick();
        chk("ar_idle", busy, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ar_start_pc", code_addr, 8'h00);
        tick();
        chk("ar_start_ir", ir, mem[0]);

        // random program against an instruction-level model
        for (int a = 0; a < 256; a++) begin
            w = 16'($urandom);
            if (w[15:11] == OP_STOP) w[15:11] = OP_ADD;
            mem[a] = w;
        end
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        exp_addr = 8'h00;
        exp_cnt  = 0;
        for (int n = 0; n < 300; n++) begin
            chk("rnd_vld", ir_valid, 1'b1);
            chk("rnd_ir", ir, mem[exp_addr]);
            chk("rnd_pc", code_addr, exp_addr + 8'd1);
            chk("rnd_cnt", instr_count, exp_cnt);
            chk("rnd_sat", cnt2, (exp_cnt > 3) ? 3 : exp_cnt);
            hold_ir = mem[exp_addr];
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) begin
                jump_en   = 1'($urandom);
                jump_addr = 8'($urandom);
                start     = 1'($urandom);
                tick();
                chk("rnd_hold_ir", ir, hold_ir);
                chk("rnd_hold_pc", code_addr,
                    exp_addr + 8'd1);
            end
            start = 1'b0;
            j  = 1'($urandom);
            ja = 8'($urandom);
            exec_done = 1'b1;
            jump_en   = j;
            jump_addr = ja;
            tick();
            exec_done = 1'b0;
            jump_en   = 1'b0;
            chk("rnd_fetch_gap", ir_valid, 1'b0);
            tick();
            exp_addr = j ? ja : exp_addr + 8'd1;
            exp_cnt++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
